pbr_debounce: RTL and testbench

PBR_DEBOUNCE -- requirements
Module: pbr_debounce

---
 rtl/pbr_debounce_if.sv | 34 +++
 rtl/pbr_debounce.sv | 99 +++++++++
 tb/tb_pbr_debounce.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pbr_debounce_if.sv
// Pushbutton debouncer bus: raw pads and sticky-clear in, debounced levels/events out.
interface pbr_debounce_if #(
   parameter int unsigned N_BTN = 5
);
   logic [N_BTN-1:0] btn_raw_i;
   logic [N_BTN-1:0] evt_clr_i;
   logic [N_BTN-1:0] btn_db_o;
   logic [N_BTN-1:0] btn_press_o;
   logic [N_BTN-1:0] btn_release_o;
   logic [N_BTN-1:0] btn_evt_o;
   logic             irq_o;

   // Side that owns the pads and consumes the debounced results.
   modport master (
      output btn_raw_i,
      output evt_clr_i,
      input  btn_db_o,
      input  btn_press_o,
      input  btn_release_o,
      input  btn_evt_o,
      input  irq_o
   );

   // Debouncer side.
   modport slave (
      input  btn_raw_i,
      input  evt_clr_i,
      output btn_db_o,
      output btn_press_o,
      output btn_release_o,
      output btn_evt_o,
      output irq_o
   );
endinterface

// File: rtl/pbr_debounce.sv
// Per-channel pushbutton debouncer: 2-flop synchronizer, stability counter,
// press/release pulses, sticky press flags and an OR-reduced interrupt.
module pbr_debounce #(
   parameter int unsigned N_BTN   = 5,
   parameter int unsigned CNT_MAX = 250000
) (
   input logic           wb_clk_i,
   input logic           wb_rst_ni,
   pbr_debounce_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } state_e;

   logic [N_BTN-1:0] sync1_q;
   logic [N_BTN-1:0] sync2_q;
   logic [N_BTN-1:0] db_q,      db_d;
   logic [N_BTN-1:0] press_q,   press_d;
   logic [N_BTN-1:0] release_q, release_d;
   logic [N_BTN-1:0] evt_q,     evt_d;
   logic [CNT_W-1:0] cnt_q [N_BTN];
   logic [CNT_W-1:0] cnt_d [N_BTN];
   state_e           state_c [N_BTN];

   // Two-flop synchronizer for the asynchronous pads, nothing in between.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= bus.btn_raw_i;
         sync2_q <= sync1_q;
      end
   end

   // State is implicit: a channel is pending whenever the synced level differs from db.
   always_comb begin
      db_d      = db_q;
      press_d   = '0;
      release_d = '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         cnt_d[i]   = '0;
         state_c[i] = (sync2_q[i] != db_q[i]) ? ST_PENDING : ST_STABLE;
         unique case (state_c[i])
            ST_STABLE: begin
               cnt_d[i] = '0;
            end
            ST_PENDING: begin
               if (cnt_q[i] == CNT_LAST) begin
                  db_d[i]      = sync2_q[i];
                  press_d[i]   = sync2_q[i];
                  release_d[i] = ~sync2_q[i];
                  cnt_d[i]     = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
            default: begin
               cnt_d[i] = '0;
            end
         endcase
      end
      // Sticky flag follows the visible press pulse; a coincident clear loses.
      evt_d = press_q | (evt_q & ~bus.evt_clr_i);
   end

   // Debounce state, pulse and sticky-flag registers.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         db_q      <= '0;
         press_q   <= '0;
         release_q <= '0;
         evt_q     <= '0;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         db_q      <= db_d;
         press_q   <= press_d;
         release_q <= release_d;
         evt_q     <= evt_d;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.btn_db_o      = db_q;
   assign bus.btn_press_o   = press_q;
   assign bus.btn_release_o = release_q;
   assign bus.btn_evt_o     = evt_q;
   assign bus.irq_o         = |evt_q;

endmodule

// File: tb/tb_pbr_debounce.sv
// Bench for pbr_debounce: directed scenarios with literal expectations, then
// randomized pad/clear/reset activity checked every cycle against a reference model.
module tb_pbr_debounce;
   localparam int unsigned N_BTN   = 5;
   localparam int unsigned CNT_MAX = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   pbr_debounce_if #(.N_BTN(N_BTN)) bus ();

   pbr_debounce #(.N_BTN(N_BTN), .CNT_MAX(CNT_MAX)) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .bus       (bus.slave)
   );

   // Reference model: a level is accepted once the synchronized input has
   // disagreed with the accepted level for CNT_MAX consecutive clock edges.
   logic [N_BTN-1:0] m_s1, m_s2, m_db, m_press, m_rel, m_evt;
   int               m_run [N_BTN];

   always @(posedge clk or negedge rst_n) begin
      logic [N_BTN-1:0] old_press;
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_db = '0; m_press = '0; m_rel = '0; m_evt = '0;
         for (int i = 0; i < N_BTN; i++) m_run[i] = 0;
      end else begin
         old_press = m_press;
         for (int i = 0; i < N_BTN; i++) begin
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
            if (m_s2[i] != m_db[i]) m_run[i] = m_run[i] + 1;
            else                    m_run[i] = 0;
            if (m_run[i] == CNT_MAX) begin
               m_db[i]    = m_s2[i];
               m_run[i]   = 0;
               m_press[i] = m_db[i];
               m_rel[i]   = ~m_db[i];
            end
         end
         m_evt = old_press | (m_evt & ~bus.evt_clr_i);
         m_s2  = m_s1;
         m_s1  = bus.btn_raw_i;
      end
   end

   function automatic logic [20:0] outs();
      return {bus.btn_db_o, bus.btn_press_o, bus.btn_release_o, bus.btn_evt_o, bus.irq_o};
   endfunction

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      logic [20:0] exp_v;
      exp_v = {m_db, m_press, m_rel, m_evt, |m_evt};
      n_cmp++;
      if (outs() !== exp_v) begin
         n_err++;
         $display("FAIL model_cycle t=%0t got db=%b pr=%b rl=%b ev=%b irq=%b expected db=%b pr=%b rl=%b ev=%b irq=%b",
                  $time, bus.btn_db_o, bus.btn_press_o, bus.btn_release_o, bus.btn_evt_o, bus.irq_o,
                  m_db, m_press, m_rel, m_evt, |m_evt);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
      n_cmp++;
      if (got !== exp_v) begin
         n_err++;
         $display("FAIL %s t=%0t got %0h expected %0h", name, $time, got, exp_v);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic at_drive();
      @(negedge clk);
      #2;
   endtask

   initial begin
      bus.btn_raw_i = '0;
      bus.evt_clr_i = '0;
      rst_n = 1'b0;

      // Reset and idle
      repeat (3) @(negedge clk);
      #1 chk("reset_outputs", 32'(outs()), 32'd0);
      at_drive();
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         edges(1);
         chk("idle_after_reset", 32'(outs()), 32'd0);
      end

      // Press on channel 0
      at_drive();
      bus.btn_raw_i[0] = 1'b1;
      edges(5);
      chk("press_db_edge5", 32'(bus.btn_db_o), 32'd0);
      edges(1);
      chk("press_db_edge6", 32'(bus.btn_db_o), 32'b00001);
      chk("press_pulse", 32'(bus.btn_press_o), 32'b00001);
      edges(1);
      chk("press_pulse_width", 32'(bus.btn_press_o), 32'd0);
      chk("evt_set", 32'(bus.btn_evt_o), 32'b00001);
      chk("irq_set", 32'(bus.irq_o), 32'd1);

      // Bounce on channel 1: high for three samples only
      at_drive();
      bus.btn_raw_i[1] = 1'b1;
      repeat (3) @(posedge clk);
      at_drive();
      bus.btn_raw_i[1] = 1'b0;
      for (int c = 0; c < 12; c++) begin
         edges(1);
         chk("bounce_quiet", 32'({bus.btn_db_o[1], bus.btn_press_o[1], bus.btn_evt_o[1]}), 32'd0);
      end

      // Release on channel 0
      at_drive();
      bus.btn_raw_i[0] = 1'b0;
      edges(5);
      chk("release_edge5", 32'(bus.btn_release_o), 32'd0);
      edges(1);
      chk("release_pulse", 32'(bus.btn_release_o), 32'b00001);
      chk("release_db", 32'(bus.btn_db_o), 32'd0);
      chk("evt_survives_release", 32'(bus.btn_evt_o), 32'b00001);
      edges(1);
      chk("release_pulse_width", 32'(bus.btn_release_o), 32'd0);

      // Clear coinciding with a new press, then clear alone
      at_drive();
      bus.btn_raw_i[0] = 1'b1;
      edges(6);
      chk("repress_pulse", 32'(bus.btn_press_o), 32'b00001);
      at_drive();
      bus.evt_clr_i[0] = 1'b1;
      edges(1);
      chk("evt_set_wins", 32'(bus.btn_evt_o), 32'b00001);
      edges(1);
      chk("evt_cleared", 32'(bus.btn_evt_o), 32'd0);
      chk("irq_cleared", 32'(bus.irq_o), 32'd0);
      at_drive();
      bus.evt_clr_i = '0;

      // Reset in the middle of a pending change on channel 2
      at_drive();
      bus.btn_raw_i = 5'b00100;
      repeat (3) @(posedge clk);
      at_drive();
      rst_n = 1'b0;
      #1 chk("reset_mid_pending", 32'(outs()), 32'd0);
      at_drive();
      at_drive();
      rst_n = 1'b1;
      edges(5);
      chk("post_reset_db_edge5", 32'(bus.btn_db_o), 32'd0);
      edges(1);
      chk("post_reset_db_edge6", 32'(bus.btn_db_o), 32'b00100);
      chk("post_reset_press", 32'(bus.btn_press_o), 32'b00100);
      edges(1);
      chk("post_reset_press_width", 32'(bus.btn_press_o), 32'd0);

      // Randomized activity: fast bouncing, then slower changes
      for (int c = 0; c < 4000; c++) begin
         int unsigned flip_range;
         flip_range = (c < 2000) ? 5 : 14;
         at_drive();
         for (int b = 0; b < N_BTN; b++) begin
            if ($urandom_range(flip_range) == 0) bus.btn_raw_i[b] = ~bus.btn_raw_i[b];
         end
         bus.evt_clr_i = ($urandom_range(7) == 0) ? N_BTN'($urandom) : '0;
         rst_n = ($urandom_range(499) == 0) ? 1'b0 : 1'b1;
      end
      at_drive();
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
